commit_trace_encoder: RTL and testbench

COMMIT_TRACE_ENCODER -- requirements
Module: commit_trace_encoder

---
 rtl/commit_trace_encoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_commit_trace_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_encoder.sv
// Commit trace encoder: per-cycle XRF/VRF/DMEM/PC commit events are queued in a FIFO and
// serialised as header[/timestamp]/payload words. Define TRACE_TIMESTAMP_EN for timestamps.
module commit_trace_encoder #(
  parameter int XLEN            = 32,
  parameter int VLEN            = 128,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int PC_WIDTH        = 10,
  parameter int DEPTH           = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       xwe,
  input  logic [4:0]                 xwaddr,
  input  logic [XLEN-1:0]            xwdata,
  input  logic                       vwe,
  input  logic [4:0]                 vwaddr,
  input  logic [VLEN-1:0]            vwdata,
  input  logic                       dwe,
  input  logic [DATA_ADDR_WIDTH-1:0] dwaddr,
  input  logic [31:0]                dwdata,
  input  logic [3:0]                 dwmask,
  input  logic                       pc_valid,
  input  logic [PC_WIDTH-1:0]        pc,
  output logic                       tr_valid,
  output logic [31:0]                tr_data,
  output logic                       tr_last,
  input  logic                       tr_ready,
  output logic                       ovf,
  output logic                       idle
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VW = VLEN / 32;
  localparam int IW = (VW > 1) ? $clog2(VW) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0] R_PC = 2'd0;
  localparam logic [1:0] R_X  = 2'd1;
  localparam logic [1:0] R_V  = 2'd2;
  localparam logic [1:0] R_D  = 2'd3;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, TS = 2'd2, DATA = 2'd3} state_t;
  logic [31:0]                m_ts    [DEPTH];
  logic [31:0]                ts_cnt;
`else
  localparam bit TS_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd3} state_t;
`endif

  // Flag bit i marks record type i present (0 PC, 1 X, 2 V, 3 D).
  logic [3:0]                 m_flags [DEPTH];
  logic [PC_WIDTH-1:0]        m_pc    [DEPTH];
  logic [4:0]                 m_xaddr [DEPTH];
  logic [31:0]                m_xdata [DEPTH];
  logic [4:0]                 m_vaddr [DEPTH];
  logic [VLEN-1:0]            m_vdata [DEPTH];
  logic [DATA_ADDR_WIDTH-1:0] m_daddr [DEPTH];
  logic [31:0]                m_ddata [DEPTH];
  logic [3:0]                 m_dmask [DEPTH];

  state_t        state, nxt_state;
  logic [1:0]    rec, nxt_rec;
  logic [IW-1:0] widx, nxt_widx;
  logic [AW-1:0] rd_ptr, wr_ptr, sel_ptr;
  logic [AW:0]   count, nxt_count;
  logic          push_req, push_ok, pop, accept, load, idle_nxt;
  logic [2:0]    head_first, next_first, cur_next;
  logic [IW:0]   npay;
  logic [15:0]   haddr;
  logic [3:0]    hmask;
  logic [31:0]   pword, nxt_word;
  logic          nxt_last;

  // Lowest flagged record type at or above start; bit 2 set when one exists.
  function automatic logic [2:0] find_rec(input logic [3:0] flags, input logic [2:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      res = (flags[i] && (3'(i) >= start)) ? {1'b1, 2'(i)} : res;
    end
    return res;
  endfunction

  function automatic logic [IW:0] pay_words(input logic [1:0] r);
    case (r)
      R_PC:    pay_words = (IW+1)'(0);
      R_V:     pay_words = (IW+1)'(VW);
      default: pay_words = (IW+1)'(1);
    endcase
  endfunction

  // Serializer next-state, FIFO push/pop decisions and the next output word.
  always_comb begin
    push_req   = pc_valid | (xwe & (xwaddr != 5'd0)) | vwe | dwe;
    accept     = tr_valid & tr_ready;
    head_first = find_rec(m_flags[rd_ptr], 3'd0);
    next_first = find_rec(m_flags[rd_ptr + AW'(1)], 3'd0);
    cur_next   = find_rec(m_flags[rd_ptr], {1'b0, rec} + 3'd1);
    sel_ptr    = rd_ptr;
    nxt_state  = state;
    nxt_rec    = rec;
    nxt_widx   = widx;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != (AW+1)'(0)) begin
          load      = 1'b1;
          nxt_state = HDR;
          nxt_rec   = head_first[1:0];
        end else begin
          nxt_state = IDLE;
        end
      end
      default: begin
        if (!accept) begin
          load = 1'b0;
        end else if (!tr_last) begin
          load = 1'b1;
          if (state == HDR) begin
`ifdef TRACE_TIMESTAMP_EN
            nxt_state = TS;
`else
            nxt_state = DATA;
`endif
            nxt_widx = '0;
          end else if (state == DATA) begin
            nxt_widx = widx + IW'(1);
          end else begin
            nxt_state = DATA;
            nxt_widx  = '0;
          end
        end else if (cur_next[2]) begin
          load      = 1'b1;
          nxt_state = HDR;
          nxt_rec   = cur_next[1:0];
        end else begin
          // Entry finished: the following entry is loaded straight from storage.
          pop = 1'b1;
          if (count > (AW+1)'(1)) begin
            sel_ptr   = rd_ptr + AW'(1);
            load      = 1'b1;
            nxt_state = HDR;
            nxt_rec   = next_first[1:0];
          end else begin
            nxt_state = IDLE;
          end
        end
      end
    endcase

    push_ok = push_req & ((count != FULL_CNT) | pop);
    case ({push_ok, pop})
      2'b10:   nxt_count = count + (AW+1)'(1);
      2'b01:   nxt_count = count - (AW+1)'(1);
      default: nxt_count = count;
    endcase
    idle_nxt = (nxt_count == (AW+1)'(0)) && (nxt_state == IDLE);

    npay = pay_words(nxt_rec);
    case (nxt_rec)
      R_PC:    haddr = 16'(m_pc[sel_ptr]);
      R_X:     haddr = 16'(m_xaddr[sel_ptr]);
      R_V:     haddr = 16'(m_vaddr[sel_ptr]);
      default: haddr = 16'(m_daddr[sel_ptr]);
    endcase
    case (nxt_rec)
      R_X:     pword = m_xdata[sel_ptr];
      R_V:     pword = m_vdata[sel_ptr][{nxt_widx, 5'd0} +: 32];
      default: pword = m_ddata[sel_ptr];
    endcase
    hmask = (nxt_rec == R_D) ? m_dmask[sel_ptr] : 4'h0;
    case (nxt_state)
      HDR: begin
        nxt_word = {2'b00, nxt_rec, hmask, 8'h00, haddr};
        nxt_last = (npay == (IW+1)'(0)) && !TS_EN;
      end
`ifdef TRACE_TIMESTAMP_EN
      TS: begin
        nxt_word = m_ts[sel_ptr];
        nxt_last = (npay == (IW+1)'(0));
      end
`endif
      DATA: begin
        nxt_word = pword;
        nxt_last = ({1'b0, nxt_widx} == (npay - (IW+1)'(1)));
      end
      default: begin
        nxt_word = 32'h0000_0000;
        nxt_last = 1'b0;
      end
    endcase
  end

  // Entry storage; occupancy lives in the pointers so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      m_flags[wr_ptr] <= {dwe, vwe, xwe & (xwaddr != 5'd0), pc_valid};
      m_pc[wr_ptr]    <= pc;
      m_xaddr[wr_ptr] <= xwaddr;
      m_xdata[wr_ptr] <= 32'(xwdata);
      m_vaddr[wr_ptr] <= vwaddr;
      m_vdata[wr_ptr] <= vwdata;
      m_daddr[wr_ptr] <= dwaddr;
      m_ddata[wr_ptr] <= dwdata;
      m_dmask[wr_ptr] <= dwmask;
`ifdef TRACE_TIMESTAMP_EN
      m_ts[wr_ptr]    <= ts_cnt;
`endif
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Free-running cycle stamp, zero in the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= 32'h0000_0000;
    end else begin
      ts_cnt <= ts_cnt + 32'h0000_0001;
    end
  end
`endif

  // FIFO pointers, serializer state and the registered trace outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rec      <= R_PC;
      widx     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tr_valid <= 1'b0;
      tr_data  <= 32'h0000_0000;
      tr_last  <= 1'b0;
      ovf      <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state  <= nxt_state;
      rec    <= nxt_rec;
      widx   <= nxt_widx;
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= nxt_count;
      ovf    <= ovf | (push_req & ~push_ok);
      idle   <= idle_nxt;
      if (load) begin
        tr_valid <= 1'b1;
        tr_data  <= nxt_word;
        tr_last  <= nxt_last;
      end else if (accept) begin
        tr_valid <= 1'b0;
        tr_last  <= 1'b0;
      end else begin
        tr_valid <= tr_valid;
        tr_last  <= tr_last;
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_encoder.sv
// Self-checking bench for commit_trace_encoder: a record-level model builds the expected
// word stream from each committed event; follows TRACE_TIMESTAMP_EN when defined.
module tb_commit_trace_encoder;
  localparam int DEPTH = 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         xwe = 1'b0, vwe = 1'b0, dwe = 1'b0, pc_valid = 1'b0, tr_ready = 1'b0;
  logic [4:0]   xwaddr = 5'd0, vwaddr = 5'd0;
  logic [31:0]  xwdata = 32'd0, dwdata = 32'd0;
  logic [127:0] vwdata = 128'd0;
  logic [9:0]   dwaddr = 10'd0, pc = 10'd0;
  logic [3:0]   dwmask = 4'd0;
  logic         tr_valid, tr_last, ovf, idle;
  logic [31:0]  tr_data;

  commit_trace_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .xwe(xwe), .xwaddr(xwaddr), .xwdata(xwdata),
    .vwe(vwe), .vwaddr(vwaddr), .vwdata(vwdata),
    .dwe(dwe), .dwaddr(dwaddr), .dwdata(dwdata), .dwmask(dwmask),
    .pc_valid(pc_valid), .pc(pc),
    .tr_valid(tr_valid), .tr_data(tr_data), .tr_last(tr_last), .tr_ready(tr_ready),
    .ovf(ovf), .idle(idle)
  );

  typedef struct packed {
    logic         pcv;
    logic [9:0]   pc;
    logic         xwe;
    logic [4:0]   xa;
    logic [31:0]  xd;
    logic         vwe;
    logic [4:0]   va;
    logic [127:0] vd;
    logic         dwe;
    logic [9:0]   da;
    logic [31:0]  dd;
    logic [3:0]   dm;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];     // {last, word} expected, in order
  logic [32:0] got_q[$];     // {last, word} accepted from the DUT
  int          ent_q[$];     // words still outstanding per buffered entry
  bit          exp_ovf = 1'b0;
  int unsigned cyc = 0;
  int          stall_err = 0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_word = 33'd0;

  function automatic int add_rec(input logic [3:0] typ, input logic [3:0] mask,
                                 input logic [15:0] addr, input logic [31:0] ts,
                                 input int npay, input logic [127:0] pay);
    logic [31:0] hdr;
    hdr = {typ, mask, 8'h00, addr};
    exp_q.push_back({(npay == 0) && !TS_EN, hdr});
    if (TS_EN) exp_q.push_back({npay == 0, ts});
    for (int k = 0; k < npay; k++) exp_q.push_back({k == npay - 1, pay[32*k +: 32]});
    return 1 + (TS_EN ? 1 : 0) + npay;
  endfunction

  function automatic void model_push(input ev_t e, input int unsigned ts);
    int  n;
    bit  has_x;
    has_x = e.xwe && (e.xa != 5'd0);
    if (!(e.pcv || has_x || e.vwe || e.dwe)) return;
    if (ent_q.size() >= DEPTH) begin
      exp_ovf = 1'b1;
      return;
    end
    n = 0;
    if (e.pcv)  n += add_rec(4'd0, 4'd0, {6'd0, e.pc}, ts, 0, 128'd0);
    if (has_x)  n += add_rec(4'd1, 4'd0, {11'd0, e.xa}, ts, 1, {96'd0, e.xd});
    if (e.vwe)  n += add_rec(4'd2, 4'd0, {11'd0, e.va}, ts, 4, e.vd);
    if (e.dwe)  n += add_rec(4'd3, e.dm, {6'd0, e.da}, ts, 1, {96'd0, e.dd});
    ent_q.push_back(n);
  endfunction

  // One clock: record the accepted word, apply inputs, advance model, return at negedge.
  task automatic drive(input ev_t e, input logic rdy);
    logic acc;
    if (prev_stall && (tr_valid !== 1'b1 || {tr_last, tr_data} !== prev_word)) stall_err++;
    acc        = (tr_valid === 1'b1) && rdy;
    prev_stall = (tr_valid === 1'b1) && !rdy;
    prev_word  = {tr_last, tr_data};
    pc_valid = e.pcv; pc = e.pc;
    xwe = e.xwe; xwaddr = e.xa; xwdata = e.xd;
    vwe = e.vwe; vwaddr = e.va; vwdata = e.vd;
    dwe = e.dwe; dwaddr = e.da; dwdata = e.dd; dwmask = e.dm;
    tr_ready = rdy;
    if (acc) begin
      got_q.push_back({tr_last, tr_data});
      if (ent_q.size() > 0) begin
        ent_q[0] = ent_q[0] - 1;
        if (ent_q[0] == 0) void'(ent_q.pop_front());
      end
    end
    if (rst_n) model_push(e, cyc);
    @(posedge clk);
    if (rst_n) cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); ent_q.delete();
    exp_ovf = 1'b0; prev_stall = 1'b0; stall_err = 0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ent_q.size() == 0 && idle === 1'b1 && tr_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      drive('0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc_valid = 1'b1; xwe = 1'b1; xwaddr = 5'd9; vwe = 1'b1; dwe = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", tr_valid); end
    checks++; if (tr_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", tr_last); end
    checks++; if (tr_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", tr_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    clear_model();
    rst_n = 1'b1; cyc = 0;
    repeat (2) drive('0, 1'b1);
    checks++;
    if (idle !== 1'b1 || tr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_events_ignored got idle=%b valid=%b exp idle=1 valid=0", idle, tr_valid);
    end
  endtask

  task automatic test_single_x();
    ev_t e;
    bit  ok;
    e = '0; e.xwe = 1'b1; e.xa = 5'd5; e.xd = 32'hDEAD_BEEF;
    drive(e, 1'b1);
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL x_no_bypass got valid=%b exp 0", tr_valid); end
    drive('0, 1'b1);
    checks++;
    if (tr_valid !== 1'b1 || tr_data !== 32'h1000_0005) begin
      errors++; $display("FAIL x_latency got valid=%b data=%h exp valid=1 data=10000005", tr_valid, tr_data);
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL x_drain got timeout exp idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL x_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL x_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    clear_model();
  endtask

  task automatic test_multi();
    ev_t e;
    bit  ok;
    int  dpos;
    e = '0;
    e.pcv = 1'b1; e.pc = 10'h04C;
    e.vwe = 1'b1; e.va = 5'd3; e.vd = 128'h3322_1100_7766_5544_BBAA_9988_0011_2233;
    e.dwe = 1'b1; e.da = 10'h010; e.dm = 4'hF; e.dd = 32'hCAFE_F00D;
    drive(e, 1'b1);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_drain got timeout exp idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    dpos = TS_EN ? 8 : 6;
    checks++;
    if (got_q.size() <= dpos || got_q[0][31:0] !== 32'h0000_004C || got_q[dpos][31:0] !== 32'h3F00_0010) begin
      errors++; $display("FAIL multi_hdrs got %0d words exp pc hdr 0000004c and d hdr 3f000010 at %0d", got_q.size(), dpos);
    end
    clear_model();
  endtask

  task automatic test_x0();
    ev_t e;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.xwe = 1'b1; e.xa = 5'd0; e.xd = $urandom;
      drive(e, 1'b1);
      checks++;
      if (idle !== 1'b1 || tr_valid !== 1'b0) begin
        errors++; $display("FAIL x0_ignored got idle=%b valid=%b exp idle=1 valid=0", idle, tr_valid);
      end
    end
  endtask

  task automatic test_overflow();
    ev_t e;
    bit  ok;
    int  recs;
    for (int i = 0; i < 20; i++) begin
      e = '0;
      if (i < 10) begin e.xwe = 1'b1; e.xa = 5'($urandom_range(1, 31)); e.xd = $urandom; end
      drive(e, 1'b0);
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got timeout exp idle"); end
    recs = 0;
    foreach (got_q[i]) if (got_q[i][32]) recs++;
    checks++; if (recs != 8) begin errors++; $display("FAIL ovf_records got %0d exp 8", recs); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL ovf_stall got %0d changes exp 0", stall_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    int  need;
    e = '0; e.vwe = 1'b1; e.va = 5'd7; e.vd = {$urandom, $urandom, $urandom, $urandom};
    clear_model();
    drive(e, 1'b1);
    need = (TS_EN ? 2 : 1) + 2;
    for (int i = 0; i < 50 && got_q.size() < need; i++) drive('0, 1'b1);
    checks++;
    if (got_q.size() != need || tr_valid !== 1'b1 || {tr_last, tr_data} !== exp_q[need]) begin
      errors++; $display("FAIL mid_reach got %0d words cur=%h exp %0d words cur=%h", got_q.size(), {tr_last, tr_data}, need, exp_q[need]);
    end
    for (int i = 0; i < need && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tr_valid !== 1'b0 || idle !== 1'b1 || ovf !== 1'b0 || tr_last !== 1'b0) begin
      errors++; $display("FAIL mid_async got valid=%b idle=%b ovf=%b last=%b exp 0 1 0 0", tr_valid, idle, ovf, tr_last);
    end
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1; cyc = 0;
    repeat (10) drive('0, 1'b1);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale got %0d words exp 0", got_q.size()); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle); end
  endtask

  task automatic test_random();
    ev_t e;
    bit  ok;
    int  sent;
    clear_model();
    sent = 0;
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      e = '0;
      if ($urandom_range(0, 1) == 1) begin
        e.pcv = 1'($urandom); e.pc = 10'($urandom);
        e.xwe = 1'($urandom); e.xa = 5'($urandom); e.xd = $urandom;
        e.vwe = ($urandom_range(0, 3) == 0); e.va = 5'($urandom);
        e.vd  = {$urandom, $urandom, $urandom, $urandom};
        e.dwe = 1'($urandom); e.da = 10'($urandom); e.dd = $urandom; e.dm = 4'($urandom);
        if (!(e.pcv || e.xwe || e.vwe || e.dwe)) e.pcv = 1'b1;
        sent++;
      end
      drive(e, $urandom_range(0, 9) < 6);
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_drain got timeout exp idle"); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL rnd_stall got %0d changes exp 0", stall_err); end
    checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rnd_ovf got %b exp %b", ovf, exp_ovf); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_x();
    test_multi();
    test_x0();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
